// File: rtl/csr_counter_pkg.sv
// Shared CSR address map, mcountinhibit layout and address decode helper.
// Latency: n/a (types and constants). Backpressure: n/a.
// Backpressure behaviour: none.
package csr_counter_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

    localparam int MCOUNTINHIBIT_CY = 0;
    localparam int MCOUNTINHIBIT_IR = 2;
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_INHIBIT
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e sel;
        logic     is_alias;
    } csr_dec_t;

    // User aliases select the same register as their machine counterpart but flag is_alias.
    function automatic csr_dec_t csr_decode(input logic [11:0] addr, input logic shadows);
        csr_dec_t d;
        d.sel      = SEL_NONE;
        d.is_alias = 1'b0;
        case (addr)
            CSR_MCYCLE:        d.sel = SEL_MCYCLE;
            CSR_MCYCLEH:       d.sel = SEL_MCYCLEH;
            CSR_MINSTRET:      d.sel = SEL_MINSTRET;
            CSR_MINSTRETH:     d.sel = SEL_MINSTRETH;
            CSR_MCOUNTINHIBIT: d.sel = SEL_INHIBIT;
            CSR_CYCLE:    if (shadows) begin d.sel = SEL_MCYCLE;    d.is_alias = 1'b1; end
            CSR_CYCLEH:   if (shadows) begin d.sel = SEL_MCYCLEH;   d.is_alias = 1'b1; end
            CSR_INSTRET:  if (shadows) begin d.sel = SEL_MINSTRET;  d.is_alias = 1'b1; end
            CSR_INSTRETH: if (shadows) begin d.sel = SEL_MINSTRETH; d.is_alias = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csr_counter_ctrl_if.sv
// CSR access bus between the decode stage and the counter controller.
// Latency: read data and status are combinational. Backpressure: none, accesses complete in one cycle.
// Backpressure behaviour: none.
interface csr_counter_ctrl_if #(
    parameter int XLEN = 32
);
    logic [11:0]     csr_addr;
    logic            csr_re;
    logic            csr_we;
    logic [XLEN-1:0] csr_wd;
    logic [XLEN-1:0] csr_rd;
    logic            csr_hit;
    logic            csr_illegal;

    modport master (
        output csr_addr, csr_re, csr_we, csr_wd,
        input  csr_rd, csr_hit, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_re, csr_we, csr_wd,
        output csr_rd, csr_hit, csr_illegal
    );
endinterface

// File: rtl/csr_counter_ctrl_counter64.sv
// Double-width counter with per-half write, single-cycle carry and registered wrap pulse.
// Latency: writes and increments visible the cycle after; ovf one cycle after the wrapping edge.
// Backpressure behaviour: none; a write to either half suppresses that cycle's increment.
module csr_counter64 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we_lo,
    input  logic           we_hi,
    input  logic [W-1:0]   wd,
    input  logic           inc,
    output logic [2*W-1:0] value,
    output logic           ovf
);

    logic [W-1:0] lo_q;
    logic [W-1:0] hi_q;
    logic         ovf_q;
    logic         lo_carry;
    logic         wrap;

    assign lo_carry = &lo_q;
    assign wrap     = lo_carry & (&hi_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_q  <= '0;
            hi_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            // Any write claims the whole counter: the untouched half holds, no carry.
            if (we_lo || we_hi) begin
                if (we_lo) lo_q <= wd;
                if (we_hi) hi_q <= wd;
            end else if (inc) begin
                lo_q <= lo_q + W'(1);
                if (lo_carry) hi_q <= hi_q + W'(1);
                ovf_q <= wrap;
            end
        end
    end

    assign value = {hi_q, lo_q};
    assign ovf   = ovf_q;

endmodule

// File: rtl/csr_counter_ctrl.sv
// Machine-mode cycle/instret counters and mcountinhibit: decode, read mux, inhibit gating.
// Latency: reads combinational (pre-update value); writes visible next cycle.
// Backpressure behaviour: none; alias writes are flagged illegal and dropped.
module csr_counter_ctrl
    import csr_counter_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int HAS_USER_SHADOWS = 1
) (
    input  logic                clk,
    input  logic                reset,
    csr_counter_ctrl_if.slave   csr,
    input  logic                instr_retire,
    output logic                cycle_ovf,
    output logic                instret_ovf
);

    localparam logic [XLEN-1:0] INH_MASK = XLEN'(MCOUNTINHIBIT_MASK);

    csr_dec_t        dec;
    logic            access;
    logic            wr_ok;
    logic            cy_we_lo, cy_we_hi;
    logic            ir_we_lo, ir_we_hi;
    logic            inh_we;
    logic            cy_inc, ir_inc;
    logic [XLEN-1:0] mcountinhibit_q;
    logic [2*XLEN-1:0] cycle_val;
    logic [2*XLEN-1:0] instret_val;
    logic [XLEN-1:0] rd_sel;

    assign dec    = csr_decode(csr.csr_addr, HAS_USER_SHADOWS != 0);
    assign access = csr.csr_re | csr.csr_we;
    assign wr_ok  = csr.csr_we & ~dec.is_alias;

    assign cy_we_lo = wr_ok & (dec.sel == SEL_MCYCLE);
    assign cy_we_hi = wr_ok & (dec.sel == SEL_MCYCLEH);
    assign ir_we_lo = wr_ok & (dec.sel == SEL_MINSTRET);
    assign ir_we_hi = wr_ok & (dec.sel == SEL_MINSTRETH);
    assign inh_we   = wr_ok & (dec.sel == SEL_INHIBIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcountinhibit_q <= '0;
        end else if (inh_we) begin
            mcountinhibit_q <= csr.csr_wd & INH_MASK;
        end
    end

    // Gating uses the registered inhibit, so a write only affects the following cycles.
    assign cy_inc = ~mcountinhibit_q[MCOUNTINHIBIT_CY];
    assign ir_inc = instr_retire & ~mcountinhibit_q[MCOUNTINHIBIT_IR];

    csr_counter64 #(.W(XLEN)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .we_lo (cy_we_lo),
        .we_hi (cy_we_hi),
        .wd    (csr.csr_wd),
        .inc   (cy_inc),
        .value (cycle_val),
        .ovf   (cycle_ovf)
    );

    csr_counter64 #(.W(XLEN)) u_instret (
        .clk   (clk),
        .reset (reset),
        .we_lo (ir_we_lo),
        .we_hi (ir_we_hi),
        .wd    (csr.csr_wd),
        .inc   (ir_inc),
        .value (instret_val),
        .ovf   (instret_ovf)
    );

    always_comb begin
        rd_sel = '0;
        case (dec.sel)
            SEL_MCYCLE:    rd_sel = cycle_val[XLEN-1:0];
            SEL_MCYCLEH:   rd_sel = cycle_val[2*XLEN-1:XLEN];
            SEL_MINSTRET:  rd_sel = instret_val[XLEN-1:0];
            SEL_MINSTRETH: rd_sel = instret_val[2*XLEN-1:XLEN];
            SEL_INHIBIT:   rd_sel = mcountinhibit_q;
            default:       rd_sel = '0;
        endcase
    end

    assign csr.csr_hit     = access & (dec.sel != SEL_NONE);
    assign csr.csr_rd      = csr.csr_hit ? rd_sel : '0;
    assign csr.csr_illegal = csr.csr_we & dec.is_alias;

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Bench for csr_counter_ctrl: directed scenarios plus randomized accesses against a 64-bit arithmetic model.
module tb_csr_counter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic instr_retire;
    logic cycle_ovf;
    logic instret_ovf;

    csr_counter_ctrl_if #(.XLEN(32)) csr_bus ();

    csr_counter_ctrl #(.XLEN(32), .HAS_USER_SHADOWS(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .csr          (csr_bus),
        .instr_retire (instr_retire),
        .cycle_ovf    (cycle_ovf),
        .instret_ovf  (instret_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: whole counters as 64-bit numbers.
    logic [63:0] m_cycle, m_instret;
    logic [31:0] m_inh;
    logic        m_cy_ovf, m_ir_ovf;

    logic [11:0] addr_tab [0:11] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                     12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                     12'h123, 12'hB01, 12'h000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_alias(input logic [11:0] a);
        return (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) || (a == 12'hC82);
    endfunction

    function automatic bit m_owned(input logic [11:0] a);
        return m_alias(a) || (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) ||
               (a == 12'hB82) || (a == 12'h320);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'h320:          return m_inh;
            default:          return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_cycle = 64'h0; m_instret = 64'h0; m_inh = 32'h0;
        m_cy_ovf = 1'b0; m_ir_ovf = 1'b0;
    endtask

    task automatic m_update(input logic [11:0] a, input logic we, input logic [31:0] wd, input logic ret);
        bit wr;
        wr = we && !m_alias(a);
        m_cy_ovf = 1'b0;
        m_ir_ovf = 1'b0;
        if (wr && a == 12'hB00)      m_cycle[31:0]  = wd;
        else if (wr && a == 12'hB80) m_cycle[63:32] = wd;
        else if (!m_inh[0]) begin
            m_cy_ovf = (m_cycle == 64'hFFFF_FFFF_FFFF_FFFF);
            m_cycle  = m_cycle + 64'd1;
        end
        if (wr && a == 12'hB02)      m_instret[31:0]  = wd;
        else if (wr && a == 12'hB82) m_instret[63:32] = wd;
        else if (ret && !m_inh[2]) begin
            m_ir_ovf  = (m_instret == 64'hFFFF_FFFF_FFFF_FFFF);
            m_instret = m_instret + 64'd1;
        end
        if (wr && a == 12'h320) m_inh = wd & 32'h5;
    endtask

    // One clock: drive at the falling edge, check combinational outputs, advance the model at the rising edge.
    task automatic step(input logic [11:0] a, input logic re, input logic we,
                        input logic [31:0] wd, input logic ret);
        bit exp_hit;
        csr_bus.csr_addr = a;
        csr_bus.csr_re   = re;
        csr_bus.csr_we   = we;
        csr_bus.csr_wd   = wd;
        instr_retire     = ret;
        #1;
        exp_hit = m_owned(a) && (re || we);
        chk("hit", csr_bus.csr_hit, exp_hit);
        chk("rd", csr_bus.csr_rd, exp_hit ? m_read(a) : 32'h0);
        chk("illegal", csr_bus.csr_illegal, we && m_alias(a));
        chk("cycle_ovf", cycle_ovf, m_cy_ovf);
        chk("instret_ovf", instret_ovf, m_ir_ovf);
        @(posedge clk);
        m_update(a, we, wd, ret);
        @(negedge clk);
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] v);
        csr_bus.csr_addr = a;
        csr_bus.csr_re   = 1'b1;
        csr_bus.csr_we   = 1'b0;
        #1;
        v = csr_bus.csr_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [11:0] a;
        logic [31:0] wd;
        reset = 1'b0;
        instr_retire = 1'b0;
        csr_bus.csr_addr = 12'h0;
        csr_bus.csr_re = 1'b0;
        csr_bus.csr_we = 1'b0;
        csr_bus.csr_wd = 32'h0;
        m_reset();
        #12;
        peek(12'hB00, v); chk("rst_mcycle", v, 32'h0);
        peek(12'h320, v); chk("rst_inhibit", v, 32'h0);
        chk("rst_cycle_ovf", cycle_ovf, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Free running count
        repeat (10) step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        peek(12'hB00, v); chk("free_mcycle", v, 32'd10);
        peek(12'hB02, v); chk("free_minstret", v, 32'd0);

        // Carry from low into high half
        step(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step(12'hB80, 1'b0, 1'b1, 32'h0, 1'b0);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        peek(12'hB00, v); chk("carry_lo_0", v, 32'hFFFF_FFFF);
        peek(12'hB80, v); chk("carry_hi_0", v, 32'h0);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        peek(12'hB00, v); chk("carry_lo_1", v, 32'h0);
        peek(12'hB80, v); chk("carry_hi_1", v, 32'h1);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        peek(12'hB00, v); chk("carry_lo_2", v, 32'h1);
        peek(12'hB80, v); chk("carry_hi_2", v, 32'h1);

        // Full 64-bit wrap
        step(12'hB80, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("wrap_ovf_before", cycle_ovf, 1'b0);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_ovf_pulse", cycle_ovf, 1'b1);
        peek(12'hB00, v); chk("wrap_lo", v, 32'h0);
        peek(12'hB80, v); chk("wrap_hi", v, 32'h0);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_ovf_after", cycle_ovf, 1'b0);
        peek(12'hB00, v); chk("wrap_lo_next", v, 32'h1);

        // Inhibit both counters
        step(12'h320, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        peek(12'h320, v); chk("inhibit_mask", v, 32'h5);
        repeat (5) step(12'hB00, 1'b1, 1'b0, 32'h0, 1'b1);
        peek(12'hB00, v); chk("inhibit_cycle", v, 32'd2);
        peek(12'hB02, v); chk("inhibit_instret", v, 32'd0);
        step(12'h320, 1'b0, 1'b1, 32'h0, 1'b1);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        peek(12'hB00, v); chk("resume_cycle", v, 32'd3);
        peek(12'hB02, v); chk("resume_instret", v, 32'd1);

        // Write wins over a same-cycle retire
        step(12'hB02, 1'b0, 1'b1, 32'd100, 1'b1);
        peek(12'hB02, v); chk("minstret_write", v, 32'd100);
        step(12'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        peek(12'hB02, v); chk("minstret_next", v, 32'd101);

        // Alias write is illegal and has no effect, read still returns data
        csr_bus.csr_addr = 12'hC00; csr_bus.csr_re = 1'b1;
        csr_bus.csr_we = 1'b1; csr_bus.csr_wd = 32'h1234;
        #1;
        chk("alias_illegal", csr_bus.csr_illegal, 1'b1);
        chk("alias_rd", csr_bus.csr_rd, 32'd5);
        step(12'hC00, 1'b1, 1'b1, 32'h1234, 1'b0);
        peek(12'hB00, v); chk("alias_no_effect", v, 32'd6);
        step(12'h123, 1'b1, 1'b1, 32'hDEAD, 1'b0);

        // Randomized accesses
        repeat (400) begin
            a = addr_tab[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0: wd = 32'hFFFF_FFFF;
                1: wd = 32'hFFFF_FFFE;
                2: wd = $urandom_range(0, 7);
                default: wd = $urandom;
            endcase
            step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), wd,
                 1'($urandom_range(0, 1)));
        end

        // Reset while both overflow pulses are high and inhibit is non-zero
        step(12'h320, 1'b0, 1'b1, 32'h0, 1'b0);
        step(12'hB82, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(12'hB02, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(12'hB80, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(12'hB00, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(12'h320, 1'b0, 1'b1, 32'h5, 1'b1);
        chk("pre_rst_cycle_ovf", cycle_ovf, 1'b1);
        chk("pre_rst_instret_ovf", instret_ovf, 1'b1);
        peek(12'h320, v); chk("pre_rst_inhibit", v, 32'h5);
        #1;
        reset = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_cycle_ovf", cycle_ovf, 1'b0);
        chk("mid_rst_instret_ovf", instret_ovf, 1'b0);
        peek(12'h320, v); chk("mid_rst_inhibit", v, 32'h0);
        peek(12'hB80, v); chk("mid_rst_mcycleh", v, 32'h0);
        peek(12'hB82, v); chk("mid_rst_minstreth", v, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(12'hB00, 1'b1, 1'b0, 32'h0, 1'b1);
        peek(12'hB02, v); chk("post_rst_minstret", v, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
